fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage core. It owns the fetch PC and addresses the synchronous-read instruction BRAM. It applies the stall, flush and redirect controls produced by the hazard unit and EX stage, and delivers `instrD`/`pcD`/`validD` to decode. A small run-control FSM holds fetch idle until the program is loaded (`start`) and stops it on `halt`.

---
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and run-control FSM.
// Drives a synchronous-read BRAM from pc_next so imem_rdata lines up with pcF.
module fetch_stage #(
    parameter int          IMEM_AW  = 15,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               flushD,
    input  logic               pc_srcE,
    input  logic [31:0]        pc_targetE,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instrD,
    output logic [31:0]        pcD,
    output logic [31:0]        pc_plus4D,
    output logic               validD,
    output logic               halted,
    output logic [31:0]        fetch_count
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

    state_e      state_q;
    logic        halted_q;
    logic [31:0] pcF_q, pcF_d;
    logic [31:0] instr_q, pcD_q, pc_plus4_q, count_q;
    logic        valid_q;
    logic        run;
    logic        bubble;

    assign run = (state_q == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (halt) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else if (start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_HALTED;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // Redirect beats stall; the target is forced word-aligned.
    always_comb begin
        pcF_d = pcF_q;
        if (run) begin
            if (pc_srcE)      pcF_d = pc_targetE & ~32'h3;
            else if (!stallF) pcF_d = pcF_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcF_q <= RESET_PC;
        else     pcF_q <= pcF_d;
    end

    // A stalled PC re-reads the same word, so the BRAM output stays stable.
    assign imem_en   = !halt && (run || (state_q == S_IDLE && start));
    assign imem_addr = pcF_d[IMEM_AW+1:2];

    assign bubble = flushD || !run || halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP;
            pcD_q      <= 32'd0;
            pc_plus4_q <= 32'd4;
            valid_q    <= 1'b0;
            count_q    <= 32'd0;
        end else if (bubble) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (!stallD) begin
            instr_q    <= imem_rdata;
            pcD_q      <= pcF_q;
            pc_plus4_q <= pcF_q + 32'd4;
            valid_q    <= 1'b1;
            count_q    <= count_q + 32'd1;
        end
    end

    assign instrD      = instr_q;
    assign pcD         = pcD_q;
    assign pc_plus4D   = pc_plus4_q;
    assign validD      = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a BRAM model feeds the DUT and expected IF/ID
// contents are queued as each step is driven, then popped after the clock edge.
module tb_fetch_stage;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst, start, halt, stallF, stallD, flushD, pc_srcE;
    logic [31:0]   pc_targetE;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   instrD, pcD, pc_plus4D, fetch_count;
    logic          validD, halted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:(1<<AW)-1];

    fetch_stage #(.IMEM_AW(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .pc_srcE(pc_srcE), .pc_targetE(pc_targetE),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcD(pcD), .pc_plus4D(pc_plus4D), .validD(validD),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] cnt);
        exp_t e;
        e.valid = v; e.instr = ins; e.pc = pc; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Advance one edge, then pop the queued expectation and compare IF/ID.
    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk); #1;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, validD}, {31'd0, e.valid});
            chk({tag, "_instr"}, instrD, e.instr);
            chk({tag, "_pc"}, pcD, e.pc);
            chk({tag, "_pc4"}, pc_plus4D, e.pc + 32'd4);
            chk({tag, "_cnt"}, fetch_count, e.cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        rst = 1'b1; start = 0; halt = 0; stallF = 0; stallD = 0; flushD = 0;
        pc_srcE = 0; pc_targetE = 32'h0;
        #2;
        chk("rst_valid", {31'd0, validD}, 32'd0);
        chk("rst_instr", instrD, 32'h13);
        chk("rst_pc", pcD, 32'h0);
        chk("rst_pc4", pc_plus4D, 32'h4);
        chk("rst_cnt", fetch_count, 32'h0);
        chk("rst_en", {31'd0, imem_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk); rst = 1'b0;
        push(0, 32'h13, 0, 0); tick_check("idle0");
        push(0, 32'h13, 0, 0); tick_check("idle1");

        // Start: RESET_PC instruction reaches D two edges later.
        start = 1; #1;
        chk("start_en", {31'd0, imem_en}, 32'd1);
        chk("start_addr", {17'd0, imem_addr}, 32'd0);
        push(0, 32'h13, 0, 0); tick_check("start_edge");
        start = 0;
        push(1, mem[0], 32'h0, 1); tick_check("run0");
        push(1, mem[1], 32'h4, 2); tick_check("run1");
        push(1, mem[2], 32'h8, 3); tick_check("run2");

        // Load-use stall: pcD=8 held one extra cycle, counted once.
        stallF = 1; stallD = 1;
        push(1, mem[2], 32'h8, 3); tick_check("stall");
        stallF = 0; stallD = 0;
        push(1, mem[3], 32'hC, 4); tick_check("post_stall");

        // Redirect to unaligned target: bubble, then word 0x40.
        pc_srcE = 1; flushD = 1; pc_targetE = 32'h42;
        push(0, 32'h13, 32'hC, 4); tick_check("redir_bubble");
        pc_srcE = 0; flushD = 0; pc_targetE = 32'h0;
        push(1, mem[16], 32'h40, 5); tick_check("redir_tgt");
        push(1, mem[17], 32'h44, 6); tick_check("redir_next");

        // Flush wins over stallD.
        flushD = 1; stallD = 1;
        push(0, 32'h13, 32'h44, 6); tick_check("flush_stall");
        flushD = 0; stallD = 0;
        push(1, mem[19], 32'h4C, 7); tick_check("after_flush");

        // Halt, then an ignored start.
        halt = 1; #1;
        chk("halt_en", {31'd0, imem_en}, 32'd0);
        chk("halt_halted_pre", {31'd0, halted}, 32'd0);
        push(0, 32'h13, 32'h4C, 7); tick_check("halt_edge");
        halt = 0;
        chk("halted", {31'd0, halted}, 32'd1);
        start = 1; #1;
        chk("halted_start_en", {31'd0, imem_en}, 32'd0);
        push(0, 32'h13, 32'h4C, 7); tick_check("halted_start");
        start = 0;
        push(0, 32'h13, 32'h4C, 7); tick_check("halted_hold");
        chk("halted_stay", {31'd0, halted}, 32'd1);

        // Leave HALTED via reset, run again, then reset mid-cycle.
        rst = 1; #1;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        rst = 0;
        start = 1;
        push(0, 32'h13, 0, 0); tick_check("restart");
        start = 0;
        push(1, mem[0], 32'h0, 1); tick_check("rerun0");
        push(1, mem[1], 32'h4, 2); tick_check("rerun1");
        #3 rst = 1; #1;
        chk("arst_valid", {31'd0, validD}, 32'd0);
        chk("arst_instr", instrD, 32'h13);
        chk("arst_cnt", fetch_count, 32'h0);
        chk("arst_en", {31'd0, imem_en}, 32'd0);
        chk("arst_pc", pcD, 32'h0);
        @(negedge clk); rst = 0;
        push(0, 32'h13, 0, 0); tick_check("post_arst");
        chk("post_arst_en", {31'd0, imem_en}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
